// File: rtl/pgm_stream_sched.sv
// Time-triggered packet stream scheduler: picks due streams round-robin and
// hands one grant at a time to the packet sender over a req/ack handshake.
module pgm_stream_sched #(
    parameter int unsigned NSTREAM = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_wr,
    input  logic [1:0]  cfg_stream,
    input  logic [63:0] cfg_start_time,
    input  logic [31:0] cfg_interval,
    input  logic [9:0]  cfg_addr,
    input  logic        run,
    input  logic [63:0] now_time,
    input  logic [31:0] num_limit,
    output logic        sched_req,
    output logic [1:0]  sched_stream,
    output logic [9:0]  sched_addr,
    input  logic        sched_ack,
    output logic [31:0] sent_cnt,
    output logic        finish,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, SCAN, ISSUE, UPDATE, DONE} state_t;

    state_t             state;
    logic [NSTREAM-1:0] valid;
    logic [63:0]        due   [NSTREAM];
    logic [31:0]        ival  [NSTREAM];
    logic [9:0]         saddr [NSTREAM];
    logic [1:0]         rr_ptr;
    logic [1:0]         gnt;

    logic [NSTREAM-1:0] elig;
    logic               any_elig;
    logic [1:0]         pick;
    logic [1:0]         idx;
    logic [31:0]        cnt_inc;
    logic [1:0]         rr_next;

    // Round-robin search: first eligible stream at or after rr_ptr, wrapping.
    always_comb begin
        elig     = '0;
        any_elig = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int unsigned i = 0; i < NSTREAM; i++) begin
            idx       = 2'(i);
            elig[idx] = valid[idx] && (now_time >= due[idx]);
        end
        for (int unsigned k = 0; k < NSTREAM; k++) begin
            idx = 2'((32'(rr_ptr) + k) % NSTREAM);
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                pick     = idx;
            end
        end
    end

    assign cnt_inc = (sent_cnt == '1) ? sent_cnt : sent_cnt + 32'd1;
    assign rr_next = (32'(gnt) == NSTREAM - 1) ? '0 : gnt + 2'd1;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            valid        <= '0;
            rr_ptr       <= '0;
            gnt          <= '0;
            sent_cnt     <= '0;
            sched_req    <= 1'b0;
            sched_stream <= '0;
            sched_addr   <= '0;
            finish       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_wr && (32'(cfg_stream) < NSTREAM)) begin
                        valid[cfg_stream] <= 1'b1;
                        due[cfg_stream]   <= cfg_start_time;
                        ival[cfg_stream]  <= (cfg_interval == '0) ? 32'd1 : cfg_interval;
                        saddr[cfg_stream] <= cfg_addr;
                    end
                    if (run) begin
                        state    <= SCAN;
                        sent_cnt <= '0;
                    end
                end
                SCAN: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (any_elig) begin
                        state        <= ISSUE;
                        gnt          <= pick;
                        sched_req    <= 1'b1;
                        sched_stream <= pick;
                        sched_addr   <= saddr[pick];
                    end
                end
                // Once raised, the request is held until acked regardless of run.
                ISSUE: begin
                    if (sched_ack) begin
                        sched_req <= 1'b0;
                        state     <= UPDATE;
                    end
                end
                UPDATE: begin
                    due[gnt] <= due[gnt] + {32'd0, ival[gnt]};
                    sent_cnt <= cnt_inc;
                    rr_ptr   <= rr_next;
                    if ((num_limit != '0) && (cnt_inc == num_limit)) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end else if (run) begin
                        state <= SCAN;
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (!run) begin
                        state  <= IDLE;
                        finish <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pgm_stream_sched.sv
// Scoreboard bench for pgm_stream_sched: directed scenarios push expected grants,
// a monitor pops and compares them at each req/ack handshake.
module tb_pgm_stream_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [1:0]  cfg_stream;
    logic [63:0] cfg_start_time;
    logic [31:0] cfg_interval;
    logic [9:0]  cfg_addr;
    logic        run;
    logic [63:0] now_time;
    logic [31:0] num_limit;
    logic        sched_req;
    logic [1:0]  sched_stream;
    logic [9:0]  sched_addr;
    logic        sched_ack;
    logic [31:0] sent_cnt;
    logic        finish;
    logic        busy;

    logic        ack_r;
    logic        stray_ack;
    logic        time_hold;
    int unsigned ack_delay;
    int unsigned ack_cnt;

    typedef struct {
        logic [1:0]  stream;
        logic [9:0]  addr;
        logic [63:0] lo;
        logic [63:0] hi;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    logic        m_prev_req;
    logic        m_prev_ack;
    logic [1:0]  m_prev_stream;
    logic [9:0]  m_prev_addr;

    int checks   = 0;
    int failures = 0;

    assign sched_ack = ack_r | stray_ack;

    pgm_stream_sched #(.NSTREAM(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_wr         (cfg_wr),
        .cfg_stream     (cfg_stream),
        .cfg_start_time (cfg_start_time),
        .cfg_interval   (cfg_interval),
        .cfg_addr       (cfg_addr),
        .run            (run),
        .now_time       (now_time),
        .num_limit      (num_limit),
        .sched_req      (sched_req),
        .sched_stream   (sched_stream),
        .sched_addr     (sched_addr),
        .sched_ack      (sched_ack),
        .sent_cnt       (sent_cnt),
        .finish         (finish),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [1:0] s, input logic [9:0] a, input logic [63:0] lo, input logic [63:0] hi);
        exp_t e;
        e.stream = s;
        e.addr   = a;
        e.lo     = lo;
        e.hi     = hi;
        exp_q.push_back(e);
    endtask

    task automatic cfg(input logic [1:0] s, input logic [63:0] st, input logic [31:0] iv, input logic [9:0] a);
        @(negedge clk);
        cfg_wr         = 1'b1;
        cfg_stream     = s;
        cfg_start_time = st;
        cfg_interval   = iv;
        cfg_addr       = a;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        run       = 1'b0;
        cfg_wr    = 1'b0;
        num_limit = '0;
        stray_ack = 1'b0;
        time_hold = 1'b0;
        ack_delay = 1;
        now_time  = '0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int unsigned limit);
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_idle(input string name, input int unsigned limit);
        int unsigned n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    task automatic wait_req(input string name, input int unsigned limit);
        int unsigned n;
        n = 0;
        while (!sched_req && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(sched_req), 64'd1);
    endtask

    task automatic wait_finish(input string name, input int unsigned limit);
        int unsigned n;
        n = 0;
        while (!finish && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(finish), 64'd1);
    endtask

    // Free-running time base, frozen while time_hold is set.
    initial begin
        forever begin
            @(negedge clk);
            if (!time_hold) now_time = now_time + 64'd1;
        end
    end

    // Sender model: acks ack_delay negedges after seeing the request.
    initial begin
        forever begin
            @(negedge clk);
            if (sched_req && !ack_r) begin
                ack_cnt++;
                if (ack_cnt >= ack_delay) ack_r = 1'b1;
            end else begin
                ack_r   = 1'b0;
                ack_cnt = 0;
            end
        end
    end

    // Monitor: compares every accepted grant and request stability while waiting.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (m_prev_req && !m_prev_ack && sched_req) begin
                check("hold_stream", 64'(sched_stream), 64'(m_prev_stream));
                check("hold_addr", 64'(sched_addr), 64'(m_prev_addr));
            end
            if (sched_req && sched_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant actual=stream%0d/addr%0h required=none", sched_stream, sched_addr);
                end else begin
                    m_e = exp_q.pop_front();
                    check("grant_stream", 64'(sched_stream), 64'(m_e.stream));
                    check("grant_addr", 64'(sched_addr), 64'(m_e.addr));
                    check("grant_time_lo", 64'(now_time >= m_e.lo), 64'd1);
                    check("grant_time_hi", 64'(now_time <= m_e.hi), 64'd1);
                end
            end
            m_prev_req    = sched_req;
            m_prev_ack    = sched_ack;
            m_prev_stream = sched_stream;
            m_prev_addr   = sched_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cfg_wr = 1'b0; cfg_stream = '0; cfg_start_time = '0;
        cfg_interval = '0; cfg_addr = '0; run = 1'b0; now_time = '0;
        num_limit = '0; stray_ack = 1'b0; time_hold = 1'b0; ack_r = 1'b0;
        ack_delay = 1; ack_cnt = 0;
        m_prev_req = 1'b0; m_prev_ack = 1'b0; m_prev_stream = '0; m_prev_addr = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_req", 64'(sched_req), 64'd0);
        check("rst_stream", 64'(sched_stream), 64'd0);
        check("rst_addr", 64'(sched_addr), 64'd0);
        check("rst_finish", 64'(finish), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sent", 64'(sent_cnt), 64'd0);

        // Single stream, due at 100/150/200.
        do_reset();
        cfg(2'd0, 64'd100, 32'd50, 10'h010);
        push(2'd0, 10'h010, 64'd100, 64'd110);
        push(2'd0, 10'h010, 64'd150, 64'd160);
        push(2'd0, 10'h010, 64'd200, 64'd210);
        run = 1'b1;
        wait_drain("t1_drain", 400);
        tick(3);
        run = 1'b0;
        wait_idle("t1_idle", 10);
        check("t1_sent", 64'(sent_cnt), 64'd3);

        // Round robin over four simultaneous streams, then the next period.
        do_reset();
        for (int i = 0; i < 4; i++) cfg(2'(i), 64'd0, 32'd1000, 10'h100 + 10'(i));
        for (int i = 0; i < 4; i++) push(2'(i), 10'h100 + 10'(i), 64'd0, 64'd999);
        run = 1'b1;
        wait_drain("t2_drain_a", 100);
        tick(20);
        check("t2_sent_a", 64'(sent_cnt), 64'd4);
        check("t2_busy", 64'(busy), 64'd1);
        @(negedge clk);
        #3 now_time = 64'd995;
        for (int i = 0; i < 4; i++) push(2'(i), 10'h100 + 10'(i), 64'd1000, 64'd1030);
        wait_drain("t2_drain_b", 100);
        tick(3);
        run = 1'b0;
        wait_idle("t2_idle", 10);
        check("t2_sent_b", 64'(sent_cnt), 64'd8);

        // Packet budget of three across two streams.
        do_reset();
        num_limit = 32'd3;
        cfg(2'd1, 64'd0, 32'd10, 10'h021);
        cfg(2'd2, 64'd0, 32'd10, 10'h032);
        push(2'd1, 10'h021, 64'd0, 64'd200);
        push(2'd2, 10'h032, 64'd0, 64'd200);
        push(2'd1, 10'h021, 64'd0, 64'd200);
        run = 1'b1;
        wait_finish("t3_finish", 200);
        check("t3_req", 64'(sched_req), 64'd0);
        check("t3_sent", 64'(sent_cnt), 64'd3);
        check("t3_busy", 64'(busy), 64'd1);
        tick(10);
        check("t3_finish_hold", 64'(finish), 64'd1);
        check("t3_req_hold", 64'(sched_req), 64'd0);
        check("t3_sent_hold", 64'(sent_cnt), 64'd3);
        run = 1'b0;
        tick(2);
        check("t3_finish_clr", 64'(finish), 64'd0);
        check("t3_idle", 64'(busy), 64'd0);
        check("t3_queue", 64'(exp_q.size()), 64'd0);
        num_limit = '0;

        // Stray ack while idle, then a 20-cycle delayed ack.
        do_reset();
        stray_ack = 1'b1;
        tick(3);
        check("t4_stray_req", 64'(sched_req), 64'd0);
        check("t4_stray_busy", 64'(busy), 64'd0);
        check("t4_stray_sent", 64'(sent_cnt), 64'd0);
        stray_ack = 1'b0;
        cfg(2'd3, 64'd0, 32'd1000, 10'h3FF);
        ack_delay = 20;
        push(2'd3, 10'h3FF, 64'd0, 64'd200);
        run = 1'b1;
        wait_req("t4_req", 50);
        for (int i = 0; i < 18; i++) begin
            tick(1);
            check("t4_req_held", 64'(sched_req), 64'd1);
            check("t4_stream_held", 64'(sched_stream), 64'd3);
            check("t4_addr_held", 64'(sched_addr), 64'h3FF);
        end
        wait_drain("t4_drain", 20);
        tick(3);
        run = 1'b0;
        wait_idle("t4_idle", 10);
        check("t4_sent", 64'(sent_cnt), 64'd1);
        ack_delay = 1;

        // run dropped mid-handshake, re-run clears count, reset mid-handshake.
        do_reset();
        cfg(2'd0, 64'd0, 32'd100, 10'h005);
        ack_delay = 5;
        push(2'd0, 10'h005, 64'd0, 64'd200);
        run = 1'b1;
        wait_req("t5_req", 50);
        run = 1'b0;
        wait_idle("t5_idle", 50);
        check("t5_sent", 64'(sent_cnt), 64'd1);
        check("t5_finish", 64'(finish), 64'd0);
        check("t5_queue", 64'(exp_q.size()), 64'd0);
        time_hold = 1'b1;
        now_time  = 64'd10;
        run = 1'b1;
        tick(2);
        check("t5_sent_clr", 64'(sent_cnt), 64'd0);
        check("t5_scan", 64'(busy), 64'd1);
        ack_delay = 30;
        time_hold = 1'b0;
        now_time  = 64'd200;
        wait_req("t5_req2", 20);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("t5_rst_req", 64'(sched_req), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_stream", 64'(sched_stream), 64'd0);
        check("t5_rst_addr", 64'(sched_addr), 64'd0);
        rst = 1'b0;
        ack_delay = 1;
        tick(20);
        check("t5_novalid_req", 64'(sched_req), 64'd0);
        check("t5_novalid_busy", 64'(busy), 64'd1);
        check("t5_novalid_sent", 64'(sent_cnt), 64'd0);
        run = 1'b0;
        wait_idle("t5_idle2", 10);

        // Config ignored while scanning; zero interval becomes 1; catch-up burst.
        do_reset();
        cfg(2'd2, 64'd1000000, 32'd5, 10'h02A);
        run = 1'b1;
        tick(3);
        check("t6_scan", 64'(busy), 64'd1);
        cfg(2'd0, 64'd0, 32'd0, 10'h055);
        tick(10);
        check("t6_ignored_sent", 64'(sent_cnt), 64'd0);
        check("t6_ignored_req", 64'(sched_req), 64'd0);
        run = 1'b0;
        wait_idle("t6_idle", 10);
        time_hold = 1'b1;
        now_time  = 64'd50;
        cfg(2'd0, 64'd48, 32'd0, 10'h055);
        cfg(2'd1, 64'd49, 32'd1, 10'h066);
        push(2'd0, 10'h055, 64'd0, 64'd100);
        push(2'd1, 10'h066, 64'd0, 64'd100);
        push(2'd0, 10'h055, 64'd0, 64'd100);
        push(2'd1, 10'h066, 64'd0, 64'd100);
        push(2'd0, 10'h055, 64'd0, 64'd100);
        run = 1'b1;
        wait_drain("t6_drain", 100);
        tick(20);
        check("t6_sent", 64'(sent_cnt), 64'd5);
        run = 1'b0;
        wait_idle("t6_idle2", 10);
        time_hold = 1'b0;

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
